// File: rtl/tiny16_mem_pkg.sv
// tiny16_mem_pkg
// Shared definitions for the tiny16 memory path. The sequencer uses them,
// and the memory block and future bus blocks will share them too.
// Contents:
//   MEM_AW / MEM_DW : default address and data widths of the memory port
//   seq_state_e     : mem_seq FSM state encoding
package tiny16_mem_pkg;

  localparam int MEM_AW = 16;
  localparam int MEM_DW = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_CAPT  = 3'd4,
    ST_RESP  = 3'd5
  } seq_state_e;

endpackage

// File: rtl/mem_seq.sv
// mem_seq
// Memory access sequencer for the tiny16 core. It takes single-word
// read/write requests on a valid/ready channel. For each request it runs the
// three-phase strobe protocol of the memory block: an address latch, then a
// write strobe or a read strobe. It returns read data, or a zero-data write
// acknowledge, on a valid/ready response channel.
//
// Build option: define MEM_SEQ_ADDR_CACHE_EN to remember the last address
// latched into memory. A request to that same address then skips the ADDR
// phase.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset (0 = reset)
//   req_valid/req_ready request handshake (req_ready is registered)
//   req_we, req_addr,   request fields, captured on accept
//   req_wdata
//   rsp_valid/rsp_ready response handshake
//   rsp_rdata           read data, 0 for write acks
//   mem_addr_en/mem_addr, mem_in_en/mem_in, mem_out_en
//                       strobes and data driven to the memory block
//   mem_out             registered read data from memory
module mem_seq
  import tiny16_mem_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          mem_addr_en,
  output logic [AW-1:0] mem_addr,
  output logic          mem_in_en,
  output logic [DW-1:0] mem_in,
  output logic          mem_out_en,
  input  logic [DW-1:0] mem_out
);

  seq_state_e    state_q, state_d;
  logic          req_ready_q, req_ready_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          mem_addr_en_q, mem_addr_en_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_in_en_q, mem_in_en_d;
  logic [DW-1:0] mem_in_q, mem_in_d;
  logic          mem_out_en_q, mem_out_en_d;
  logic          accept;
  logic          cache_hit;

  assign accept = req_valid && req_ready_q;

`ifdef MEM_SEQ_ADDR_CACHE_EN
  logic          cache_valid_q, cache_valid_d;
  logic [AW-1:0] cache_addr_q, cache_addr_d;

  // The memory block still holds the address that the last ADDR phase
  // latched. Reset clears the valid bit, so the first request after reset
  // always goes through ADDR.
  assign cache_hit = cache_valid_q && (req_addr == cache_addr_q);

  always_comb begin
    cache_valid_d = cache_valid_q;
    cache_addr_d  = cache_addr_q;
    if (state_q == ST_ADDR) begin
      cache_valid_d = 1'b1;
      cache_addr_d  = addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_valid_q <= 1'b0;
      cache_addr_q  <= '0;
    end else begin
      cache_valid_q <= cache_valid_d;
      cache_addr_q  <= cache_addr_d;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // Next-state and datapath logic. Every output is registered from the next
  // state, so the strobes follow the state register exactly and never glitch.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_in_d    = mem_in_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (cache_hit) begin
            state_d = req_we ? ST_WRITE : ST_READ;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR:  state_d = we_q ? ST_WRITE : ST_READ;
      ST_WRITE: begin
        state_d     = ST_RESP;
        rsp_rdata_d = '0;
      end
      ST_READ:  state_d = ST_CAPT;
      // memory registers its output on the edge that ends READ, so mem_out
      // is valid throughout CAPT.
      ST_CAPT: begin
        state_d     = ST_RESP;
        rsp_rdata_d = mem_out;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase

    req_ready_d   = (state_d == ST_IDLE);
    rsp_valid_d   = (state_d == ST_RESP);
    mem_addr_en_d = (state_d == ST_ADDR);
    mem_in_en_d   = (state_d == ST_WRITE);
    mem_out_en_d  = (state_d == ST_READ);

    // The address and data buses keep their last driven value between strobes.
    if (state_d == ST_ADDR) begin
      mem_addr_d = addr_d;
    end
    if (state_d == ST_WRITE) begin
      mem_in_d = wdata_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      req_ready_q   <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      mem_addr_en_q <= 1'b0;
      mem_addr_q    <= '0;
      mem_in_en_q   <= 1'b0;
      mem_in_q      <= '0;
      mem_out_en_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      mem_addr_en_q <= mem_addr_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_in_en_q   <= mem_in_en_d;
      mem_in_q      <= mem_in_d;
      mem_out_en_q  <= mem_out_en_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign mem_addr_en = mem_addr_en_q;
  assign mem_addr    = mem_addr_q;
  assign mem_in_en   = mem_in_en_q;
  assign mem_in      = mem_in_q;
  assign mem_out_en  = mem_out_en_q;

endmodule

// File: tb/tb_mem_seq.sv
// tb_mem_seq
// Directed testbench for mem_seq. A behavioural memory model answers the
// strobes. A monitor on the falling edge counts strobe pulses and strobe
// overlaps. Expected data and latencies are hand-computed constants.
// Latency is counted in rising edges. The accept edge counts as 1, and the
// edge that raises rsp_valid is the last one counted.
module tb_mem_seq;

  logic        clk;
  logic        rst;
  logic        reqValid;
  logic        reqReady;
  logic        reqWe;
  logic [15:0] reqAddr;
  logic [15:0] reqWdata;
  logic        rspValid;
  logic        rspReady;
  logic [15:0] rspRdata;
  logic        memAddrEn;
  logic [15:0] memAddr;
  logic        memInEn;
  logic [15:0] memIn;
  logic        memOutEn;
  logic [15:0] memOut;

  int checkCount;
  int passCount;
  int overlapCount;
  int addrEnCount;
  int inEnCount;
  int rspValidCount;

  logic [15:0] ram [0:255] = '{default: 16'h0000};
  logic [15:0] latchedAddr = 16'h0000;

  mem_seq dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (reqValid),
    .req_ready   (reqReady),
    .req_we      (reqWe),
    .req_addr    (reqAddr),
    .req_wdata   (reqWdata),
    .rsp_valid   (rspValid),
    .rsp_ready   (rspReady),
    .rsp_rdata   (rspRdata),
    .mem_addr_en (memAddrEn),
    .mem_addr    (memAddr),
    .mem_in_en   (memInEn),
    .mem_in      (memIn),
    .mem_out_en  (memOutEn),
    .mem_out     (memOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: the address is latched on addr_en, and the output is
  // registered one edge after out_en.
  always @(posedge clk) begin
    if (memAddrEn) latchedAddr <= memAddr;
    if (memInEn) ram[latchedAddr[7:0]] <= memIn;
    if (memOutEn) memOut <= ram[latchedAddr[7:0]];
  end

  // Strobe monitor, sampled away from the active edge
  always @(negedge clk) begin
    if ((32'(memAddrEn) + 32'(memInEn) + 32'(memOutEn)) > 1) overlapCount++;
    if (memAddrEn) addrEnCount++;
    if (memInEn) inEnCount++;
    if (rspValid) rspValidCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one request and returns its latency and response data. 'hold' keeps
  // rsp_ready low for that many cycles after rsp_valid rises, and checks that
  // the response stays stable meanwhile. 'inject' raises a write of 0xBEEF @0
  // while the sequencer is busy in READ.
  task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                               input int hold, input logic inject,
                               output int lat, output logic [15:0] rdata);
    int waitCycles;
    waitCycles = 0;
    while (!reqReady && waitCycles < 20) begin
      tick();
      waitCycles++;
    end
    if (!reqReady) checkOutput("ready_timeout", 32'(reqReady), 32'd1);
    reqValid    = 1'b1;
    reqWe       = we;
    reqAddr     = addr;
    reqWdata    = wdata;
    rspReady    = (hold == 0);
    addrEnCount = 0;
    inEnCount   = 0;
    tick();
    lat      = 1;
    reqValid = 1'b0;
    while (!rspValid && lat < 20) begin
      tick();
      lat++;
      if (inject && lat == 2) begin
        reqValid = 1'b1;
        reqWe    = 1'b1;
        reqAddr  = 16'h0000;
        reqWdata = 16'hBEEF;
      end
    end
    reqValid = 1'b0;
    rdata    = rspRdata;
    for (int i = 0; i < hold; i++) begin
      tick();
      checkOutput("bp_valid", 32'(rspValid), 32'd1);
      checkOutput("bp_rdata", 32'(rspRdata), 32'(rdata));
      checkOutput("bp_req_ready", 32'(reqReady), 32'd0);
    end
    rspReady = 1'b1;
    tick();
  endtask

  initial begin
    int lat;
    logic [15:0] rdata;
    int hitLat;
    int hitAddrEn;

`ifdef MEM_SEQ_ADDR_CACHE_EN
    hitLat    = 3;
    hitAddrEn = 0;
`else
    hitLat    = 4;
    hitAddrEn = 1;
`endif

    checkCount    = 0;
    passCount     = 0;
    overlapCount  = 0;
    addrEnCount   = 0;
    inEnCount     = 0;
    rspValidCount = 0;
    rst       = 1'b0;
    reqValid  = 1'b0;
    reqWe     = 1'b0;
    reqAddr   = 16'h0000;
    reqWdata  = 16'h0000;
    rspReady  = 1'b0;

    // Reset holds every output low, and req_ready rises one edge after release.
    tick();
    tick();
    checkOutput("rst_req_ready", 32'(reqReady), 32'd0);
    checkOutput("rst_rsp", {15'd0, rspValid, rspRdata}, 32'd0);
    checkOutput("rst_strobes", {29'd0, memAddrEn, memInEn, memOutEn}, 32'd0);
    checkOutput("rst_mem_bus", {memAddr, memIn}, 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("rel_req_ready_low", 32'(reqReady), 32'd0);
    tick();
    checkOutput("rel_req_ready_high", 32'(reqReady), 32'd1);

    // Two writes, then both read back
    applyStimulus(1'b1, 16'h0000, 16'h1234, 0, 1'b0, lat, rdata);
    checkOutput("wr0_lat", 32'(lat), 32'd3);
    checkOutput("wr0_ack", 32'(rdata), 32'd0);
    applyStimulus(1'b1, 16'h0001, 16'h4321, 0, 1'b0, lat, rdata);
    checkOutput("wr1_lat", 32'(lat), 32'd3);
    checkOutput("wr1_ack", 32'(rdata), 32'd0);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 0, 1'b0, lat, rdata);
    checkOutput("rd0_lat", 32'(lat), 32'd4);
    checkOutput("rd0_data", 32'(rdata), 32'h1234);
    applyStimulus(1'b0, 16'h0001, 16'h0000, 0, 1'b0, lat, rdata);
    checkOutput("rd1_lat", 32'(lat), 32'd4);
    checkOutput("rd1_data", 32'(rdata), 32'h4321);

    // A repeat read of the same address hits the address cache when the
    // cache is built
    applyStimulus(1'b0, 16'h0001, 16'h0000, 0, 1'b0, lat, rdata);
    checkOutput("rd1_rep_lat", 32'(lat), 32'(hitLat));
    checkOutput("rd1_rep_addr_en", 32'(addrEnCount), 32'(hitAddrEn));
    checkOutput("rd1_rep_data", 32'(rdata), 32'h4321);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 0, 1'b0, lat, rdata);
    checkOutput("rd0_miss_lat", 32'(lat), 32'd4);
    checkOutput("rd0_miss_addr_en", 32'(addrEnCount), 32'd1);
    checkOutput("rd0_miss_data", 32'(rdata), 32'h1234);

    // Backpressure: the response is held for 5 cycles
    applyStimulus(1'b0, 16'h0001, 16'h0000, 5, 1'b0, lat, rdata);
    checkOutput("bp_lat", 32'(lat), 32'd4);
    checkOutput("bp_data", 32'(rdata), 32'h4321);

    // A request raised while the sequencer is busy is ignored
    applyStimulus(1'b0, 16'h0000, 16'h0000, 0, 1'b1, lat, rdata);
    checkOutput("busy_in_en", 32'(inEnCount), 32'd0);
    checkOutput("busy_data", 32'(rdata), 32'h1234);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 0, 1'b0, lat, rdata);
    checkOutput("post_busy_lat", 32'(lat), 32'(hitLat));
    checkOutput("post_busy_data", 32'(rdata), 32'h1234);

    // Reset asserted during the ADDR phase of a write discards the write
    reqValid = 1'b1;
    reqWe    = 1'b1;
    reqAddr  = 16'h0002;
    reqWdata = 16'hAAAA;
    rspReady = 1'b1;
    tick();
    reqValid = 1'b0;
    checkOutput("mid_addr_en", 32'(memAddrEn), 32'd1);
    inEnCount     = 0;
    rspValidCount = 0;
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_outputs", {27'd0, reqReady, rspValid, memAddrEn, memInEn, memOutEn}, 32'd0);
    checkOutput("mid_rst_bus", {memAddr, memIn}, 32'd0);
    tick();
    tick();
    #2;
    rst = 1'b1;
    tick();
    tick();
    checkOutput("mid_in_en", 32'(inEnCount), 32'd0);
    checkOutput("mid_rsp_valid", 32'(rspValidCount), 32'd0);
    checkOutput("mid_req_ready", 32'(reqReady), 32'd1);
    applyStimulus(1'b0, 16'h0002, 16'h0000, 0, 1'b0, lat, rdata);
    checkOutput("after_rst_lat", 32'(lat), 32'd4);
    checkOutput("after_rst_data", 32'(rdata), 32'h0000);
    applyStimulus(1'b0, 16'h0001, 16'h0000, 0, 1'b0, lat, rdata);
    checkOutput("after_rst_rd1", 32'(rdata), 32'h4321);

    checkOutput("strobe_overlap", 32'(overlapCount), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
